// File: rtl/tagged_sorter_if.sv
// tagged_sorter_if: start/busy/done handshake and data buses between the tagging controller and the sorter.
// Ports: start, in_data (controller -> sorter); busy, done, out_data, max_value, max_index (sorter -> controller).
interface tagged_sorter_if #(
  parameter int K = 4,
  parameter int SIZE = 16
);
  localparam int VW = $clog2(SIZE);
  localparam int IW = $clog2(K);
  localparam int EW = VW + IW;
  logic start;
  logic [EW*K-1:0] in_data;
  logic busy;
  logic done;
  logic [EW*K-1:0] out_data;
  logic [VW-1:0] max_value;
  logic [IW-1:0] max_index;
  modport master(output start, in_data, input busy, done, out_data, max_value, max_index);
  modport slave(input start, in_data, output busy, done, out_data, max_value, max_index);
endinterface

// File: rtl/tagged_sorter.sv
// tagged_sorter: descending odd-even transposition sort of K {value,index} words, one phase per cycle.
// Ports: clk, rst (sync, active-high); bus.start/in_data load a sort in IDLE; bus.busy during phases;
// bus.done one-cycle pulse with out_data (slot 0 largest), max_value and max_index updated.
module tagged_sorter #(
  parameter int K = 4,
  parameter int SIZE = 16
) (
  input logic clk,
  input logic rst,
  tagged_sorter_if.slave bus
);
  localparam int VW = $clog2(SIZE);
  localparam int IW = $clog2(K);
  localparam int EW = VW + IW;
  localparam int PW = $clog2(K) + 1;
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t state;
  logic [PW-1:0] ph;
  logic [EW-1:0] w [K];
  logic [EW-1:0] nx [K];
  // Pairs start at even slots on even phases and odd slots on odd phases; pairs are disjoint.
  always_comb begin
    nx = w;
    for (int j = 0; j < K - 1; j++)
      if (j[0] == ph[0] && w[j] < w[j+1]) begin
        nx[j] = w[j+1];
        nx[j+1] = w[j];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph <= '0;
      w <= '{default: '0};
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_data <= '0;
      bus.max_value <= '0;
      bus.max_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            for (int j = 0; j < K; j++) w[j] <= bus.in_data[EW*j +: EW];
            ph <= '0;
            bus.busy <= 1'b1;
            state <= SORT;
          end
        end
        SORT: begin
          w <= nx;
          ph <= ph + 1'b1;
          // The last phase result goes straight to the shadow outputs.
          if (ph == PW'(K - 1)) begin
            for (int j = 0; j < K; j++) bus.out_data[EW*j +: EW] <= nx[j];
            bus.max_value <= nx[0][EW-1:IW];
            bus.max_index <= nx[0][IW-1:0];
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tagged_sorter.sv
// tb_tagged_sorter: directed table plus handshake corner cases on K=4, and a random sweep over K and SIZE.
module tb_tagged_sorter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int stage = 0;
  always #5 clk = ~clk;

  tagged_sorter_if #(.K(4), .SIZE(16)) m();
  tagged_sorter #(.K(4), .SIZE(16)) dut(.clk(clk), .rst(rst), .bus(m));

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask

  function automatic logic [23:0] pack4(input logic [3:0][3:0] v);
    logic [23:0] r;
    for (int j = 0; j < 4; j++) r[6*j +: 6] = {v[j], 2'(j)};
    return r;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!m.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string n, input logic [23:0] d, output int lat);
    @(negedge clk);
    m.in_data = d;
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    m.in_data = '1;
    lat = 0;
    while (!m.done && lat < 40) begin
      chk({n, "_busy"}, m.busy, 1);
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    string name;
    logic [3:0][3:0] v;
    logic [3:0][5:0] e;
    logic [3:0] mv;
    logic [1:0] mi;
  } vec_t;
  vec_t tv [5];

  initial begin
    int lat, gap, nd;
    tv[0] = '{"basic",  {4'd7, 4'd1, 4'd9, 4'd3},    {6'd6, 6'd12, 6'd31, 6'd37}, 4'd9,  2'd1};
    tv[1] = '{"equal",  {4'd5, 4'd5, 4'd5, 4'd5},    {6'd20, 6'd21, 6'd22, 6'd23}, 4'd5, 2'd3};
    tv[2] = '{"ascend", {4'd15, 4'd10, 4'd5, 4'd0},  {6'd0, 6'd21, 6'd42, 6'd63}, 4'd15, 2'd3};
    tv[3] = '{"alt",    {4'd0, 4'd15, 4'd0, 4'd15},  {6'd1, 6'd3, 6'd60, 6'd62}, 4'd15,  2'd2};
    tv[4] = '{"mixed",  {4'd9, 4'd2, 4'd8, 4'd8},    {6'd10, 6'd32, 6'd33, 6'd39}, 4'd9, 2'd3};
    m.start = 1'b0;
    m.in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out", m.out_data, 0);
    chk("rst_maxv", m.max_value, 0);
    chk("rst_maxi", m.max_index, 0);
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(tv[i].name, pack4(tv[i].v), lat);
      chk({tv[i].name, "_lat"}, lat, 4);
      chk({tv[i].name, "_out"}, m.out_data, tv[i].e);
      chk({tv[i].name, "_maxv"}, m.max_value, tv[i].mv);
      chk({tv[i].name, "_maxi"}, m.max_index, tv[i].mi);
      chk({tv[i].name, "_busy_at_done"}, m.busy, 0);
      @(negedge clk);
      chk({tv[i].name, "_done_pulse"}, m.done, 0);
    end
    chk("basic_slot0", tv[0].e[0], 6'd37);

    // start held high: mid-sort input change, stable outputs, K+2 spacing
    @(negedge clk);
    m.in_data = pack4(tv[0].v);
    m.start = 1'b1;
    @(negedge clk);
    m.in_data = pack4(tv[2].v);
    chk("held_busy", m.busy, 1);
    chk("held_prev_out", m.out_data, tv[4].e);
    wait_done(lat);
    chk("held_lat", lat, 4);
    chk("held_out_a", m.out_data, tv[0].e);
    gap = 0;
    @(negedge clk);
    gap++;
    chk("held_idle_busy", m.busy, 0);
    chk("held_idle_done", m.done, 0);
    @(negedge clk);
    gap++;
    chk("held_reload_busy", m.busy, 1);
    chk("held_keep_out", m.out_data, tv[0].e);
    chk("held_keep_maxi", m.max_index, tv[0].mi);
    while (!m.done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    m.start = 1'b0;
    chk("held_spacing", gap, 6);
    chk("held_out_b", m.out_data, tv[2].e);

    // reset during phase 2
    @(negedge clk);
    @(negedge clk);
    m.in_data = pack4(tv[3].v);
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out", m.out_data, 0);
    chk("mid_rst_maxv", m.max_value, 0);
    chk("mid_rst_maxi", m.max_index, 0);
    chk("mid_rst_busy", m.busy, 0);
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (m.done) nd++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", nd, 0);
    run_vec("after_rst", pack4(tv[1].v), lat);
    chk("after_rst_lat", lat, 4);
    chk("after_rst_out", m.out_data, tv[1].e);
    chk("after_rst_maxi", m.max_index, tv[1].mi);

    stage = 1;
    fork
      wait (stage == 7);
      repeat (5000) @(negedge clk);
    join_any
    disable fork;
    chk("sweep_complete", stage, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  for (genvar g = 0; g < 6; g++) begin : sw
    localparam int GK = g < 2 ? 2 : g < 4 ? 3 : 8;
    localparam int GS = (g % 2 == 1) ? 256 : 16;
    localparam int VW = $clog2(GS);
    localparam int IW = $clog2(GK);
    localparam int EW = VW + IW;
    tagged_sorter_if #(.K(GK), .SIZE(GS)) b();
    tagged_sorter #(.K(GK), .SIZE(GS)) u(.clk(clk), .rst(rst), .bus(b));
    initial begin
      logic [EW-1:0] e [GK];
      logic [EW-1:0] t;
      logic [EW*GK-1:0] ep;
      int lat;
      b.start = 1'b0;
      b.in_data = '0;
      wait (stage == g + 1);
      for (int r = 0; r < 4; r++) begin
        for (int j = 0; j < GK; j++) begin
          e[j] = {VW'($urandom_range(GS - 1)), IW'(j)};
          b.in_data[EW*j +: EW] = e[j];
        end
        for (int i = 0; i < GK; i++)
          for (int j = 0; j < GK - 1; j++)
            if (e[j] < e[j+1]) begin
              t = e[j];
              e[j] = e[j+1];
              e[j+1] = t;
            end
        for (int j = 0; j < GK; j++) ep[EW*j +: EW] = e[j];
        @(negedge clk);
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        lat = 0;
        while (!b.done && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("sweep_k%0d_s%0d_lat", GK, GS), lat, GK);
        chk($sformatf("sweep_k%0d_s%0d_out", GK, GS), b.out_data, ep);
        chk($sformatf("sweep_k%0d_s%0d_maxv", GK, GS), b.max_value, e[0][EW-1:IW]);
        chk($sformatf("sweep_k%0d_s%0d_maxi", GK, GS), b.max_index, e[0][IW-1:0]);
      end
      stage = g + 2;
    end
  end
endmodule
